// File: rtl/el2_dec_gpr_mp.sv
// ============================================================================
// Module   : el2_dec_gpr_mp
// Purpose  : Multi-write-port integer register file with a long-latency
//            busy scoreboard, busy count and write-collision flag.
//            Optional same-cycle read bypass: define EL2_GPR_BYPASS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module el2_dec_gpr_mp #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int NWR  = 3,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                scan_mode,
    input  logic [AW-1:0]       raddr0,
    input  logic [AW-1:0]       raddr1,
    output logic [XLEN-1:0]     rd0,
    output logic [XLEN-1:0]     rd1,
    output logic                rbusy0,
    output logic                rbusy1,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NWR-1:0]      sb_clr,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_set_addr,
    input  logic                sb_flush,
    output logic [NREG-1:0]     busy_vec,
    output logic [AW:0]         busy_cnt,
    output logic                wr_collision
);

    logic [XLEN-1:0] rf_q [1:NREG-1];
    logic [XLEN-1:0] w_rf [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;
    logic            coll_q, coll_d;

    logic [NREG-1:0] w_wr_en;
    logic [NREG-1:0] w_wr_clr;
    logic [XLEN-1:0] w_wr_data [NREG];
    logic [NREG-1:0] w_set_hit;
    logic [NREG-1:0] w_clr_vec;
    logic            w_unused;

    // Entry 0 of the decode arrays is never asserted; scan_mode has no
    // behavioural role in this flop-based implementation.
    assign w_unused = scan_mode ^ w_wr_en[0] ^ (^w_wr_data[0]);

    // Walking ports from highest to lowest lets the lowest enabled port win.
    always_comb begin
        w_wr_en  = '0;
        w_wr_clr = '0;
        for (int a = 0; a < NREG; a++) begin
            w_wr_data[a] = '0;
        end
        for (int a = 1; a < NREG; a++) begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (wen[p] && (waddr[p*AW +: AW] == AW'(a))) begin
                    w_wr_en[a]   = 1'b1;
                    w_wr_data[a] = wd[p*XLEN +: XLEN];
                    w_wr_clr[a]  = sb_clr[p];
                end
            end
        end
    end

    always_comb begin
        w_rf[0] = '0;
        for (int a = 1; a < NREG; a++) begin
            w_rf[a] = rf_q[a];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int a = 1; a < NREG; a++) begin
                rf_q[a] <= '0;
            end
        end else begin
            for (int a = 1; a < NREG; a++) begin
                if (w_wr_en[a]) begin
                    rf_q[a] <= w_wr_data[a];
                end
            end
        end
    end

    // Set beats clear, clear and flush both drop the bit.
    assign w_set_hit = (sb_set && (sb_set_addr != '0)) ? (NREG'(1) << sb_set_addr) : '0;
    assign w_clr_vec = w_wr_en & w_wr_clr;

    always_comb begin
        busy_d     = w_set_hit | (busy_q & ~w_clr_vec & {NREG{~sb_flush}});
        busy_d[0]  = 1'b0;
        busy_cnt_d = '0;
        for (int a = 0; a < NREG; a++) begin
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[a]);
        end
    end

    always_comb begin
        coll_d = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            for (int q = p + 1; q < NWR; q++) begin
                if (wen[p] && wen[q] && (waddr[p*AW +: AW] == waddr[q*AW +: AW])
                    && (waddr[p*AW +: AW] != '0)) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            coll_q     <= coll_d;
        end
    end

    assign busy_vec     = busy_q;
    assign busy_cnt     = busy_cnt_q;
    assign wr_collision = coll_q;

`ifdef EL2_GPR_BYPASS_EN
    // w_wr_en[0] is never set, so reads of x0 always fall through to zero.
    assign rd0    = w_wr_en[raddr0] ? w_wr_data[raddr0] : w_rf[raddr0];
    assign rd1    = w_wr_en[raddr1] ? w_wr_data[raddr1] : w_rf[raddr1];
    assign rbusy0 = busy_q[raddr0] & ~w_clr_vec[raddr0];
    assign rbusy1 = busy_q[raddr1] & ~w_clr_vec[raddr1];
`else
    assign rd0    = w_rf[raddr0];
    assign rd1    = w_rf[raddr1];
    assign rbusy0 = busy_q[raddr0];
    assign rbusy1 = busy_q[raddr1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_el2_dec_gpr_mp.sv
// ============================================================================
// Module   : tb_el2_dec_gpr_mp
// Purpose  : Scoreboard bench for el2_dec_gpr_mp in its default build.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_el2_dec_gpr_mp;

    localparam int NREG = 32;
    localparam int XLEN = 32;
    localparam int NWR  = 3;
    localparam int AW   = 5;

    logic                clk;
    logic                rst_l;
    logic                scan_mode;
    logic [AW-1:0]       raddr0, raddr1;
    logic [XLEN-1:0]     rd0, rd1;
    logic                rbusy0, rbusy1;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      sb_clr;
    logic                sb_set;
    logic [AW-1:0]       sb_set_addr;
    logic                sb_flush;
    logic [NREG-1:0]     busy_vec;
    logic [AW:0]         busy_cnt;
    logic                wr_collision;

    el2_dec_gpr_mp #(.NREG(NREG), .XLEN(XLEN), .NWR(NWR)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .scan_mode    (scan_mode),
        .raddr0       (raddr0),
        .raddr1       (raddr1),
        .rd0          (rd0),
        .rd1          (rd1),
        .rbusy0       (rbusy0),
        .rbusy1       (rbusy1),
        .wen          (wen),
        .waddr        (waddr),
        .wd           (wd),
        .sb_clr       (sb_clr),
        .sb_set       (sb_set),
        .sb_set_addr  (sb_set_addr),
        .sb_flush     (sb_flush),
        .busy_vec     (busy_vec),
        .busy_cnt     (busy_cnt),
        .wr_collision (wr_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [XLEN-1:0] rd0;
        logic [XLEN-1:0] rd1;
        logic            rb0;
        logic            rb1;
        logic [NREG-1:0] bv;
        logic [AW:0]     cnt;
        logic            coll;
    } exp_t;

    exp_t q[$];

    logic [XLEN-1:0] m_rf [NREG];
    logic [NREG-1:0] m_busy;
    logic            m_coll;

    function automatic logic [AW:0] popcnt(input logic [NREG-1:0] v);
        logic [AW:0] c = '0;
        for (int i = 0; i < NREG; i++) c = c + (AW+1)'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NREG; a++) m_rf[a] = '0;
        m_busy = '0;
        m_coll = 1'b0;
    endtask

    // Reference behaviour of one clock edge, from the currently driven inputs.
    task automatic model_step();
        logic [NREG-1:0] nb;
        logic            found, clr;
        nb = m_busy;
        for (int a = 1; a < NREG; a++) begin
            found = 1'b0;
            clr   = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (!found && wen[p] && (int'(waddr[p*AW +: AW]) == a)) begin
                    found   = 1'b1;
                    m_rf[a] = wd[p*XLEN +: XLEN];
                    clr     = sb_clr[p];
                end
            end
            if (clr)      nb[a] = 1'b0;
            if (sb_flush) nb[a] = 1'b0;
            if (sb_set && (int'(sb_set_addr) == a)) nb[a] = 1'b1;
        end
        m_busy = nb;
        m_coll = 1'b0;
        for (int p = 0; p < NWR; p++)
            for (int r = p + 1; r < NWR; r++)
                if (wen[p] && wen[r] && waddr[p*AW +: AW] == waddr[r*AW +: AW]
                    && waddr[p*AW +: AW] != '0)
                    m_coll = 1'b1;
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        e.rd0  = m_rf[raddr0];
        e.rd1  = m_rf[raddr1];
        e.rb0  = m_busy[raddr0];
        e.rb1  = m_busy[raddr1];
        e.bv   = m_busy;
        e.cnt  = popcnt(m_busy);
        e.coll = m_coll;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check_val("rd0",      64'(rd0),          64'(e.rd0));
        check_val("rd1",      64'(rd1),          64'(e.rd1));
        check_val("rbusy0",   64'(rbusy0),       64'(e.rb0));
        check_val("rbusy1",   64'(rbusy1),       64'(e.rb1));
        check_val("busy_vec", 64'(busy_vec),     64'(e.bv));
        check_val("busy_cnt", 64'(busy_cnt),     64'(e.cnt));
        check_val("wr_coll",  64'(wr_collision), 64'(e.coll));
    endtask

    task automatic clear_in();
        wen = '0; waddr = '0; wd = '0; sb_clr = '0;
        sb_set = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input int addr, input logic [XLEN-1:0] data, input logic clr);
        wen[p]              = 1'b1;
        waddr[p*AW +: AW]   = AW'(addr);
        wd[p*XLEN +: XLEN]  = data;
        sb_clr[p]           = clr;
    endtask

    initial begin
        scan_mode = 1'b0;
        rst_l     = 1'b0;
        raddr0    = '0;
        raddr1    = '0;
        clear_in();
        model_reset();

        #12;
        check_val("rst_busy_vec", 64'(busy_vec), 64'h0);
        check_val("rst_busy_cnt", 64'(busy_cnt), 64'h0);
        check_val("rst_coll",     64'(wr_collision), 64'h0);
        raddr0 = 5'd5;
        #1;
        check_val("rst_rd0",      64'(rd0), 64'h0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // Basic write / read-after-write and x0 immunity
        clear_in(); set_wr(0, 5, 32'hDEADBEEF, 1'b0); raddr0 = 5'd5;
        cyc();
        check_val("x5_value", 64'(rd0), 64'hDEADBEEF);
        clear_in(); set_wr(0, 0, 32'hFFFFFFFF, 1'b0); raddr0 = 5'd0;
        cyc();
        check_val("x0_zero", 64'(rd0), 64'h0);

        // Same-address collision: lowest port wins, flag lasts one cycle
        clear_in(); set_wr(0, 7, 32'h11111111, 1'b0); set_wr(2, 7, 32'h22222222, 1'b0);
        raddr1 = 5'd7;
        cyc();
        check_val("x7_prio",   64'(rd1), 64'h11111111);
        check_val("coll_set",  64'(wr_collision), 64'h1);
        clear_in();
        cyc();
        check_val("coll_drop", 64'(wr_collision), 64'h0);
        clear_in(); set_wr(0, 0, 32'h1, 1'b0); set_wr(1, 0, 32'h2, 1'b0);
        cyc();
        check_val("coll_x0",   64'(wr_collision), 64'h0);

        // Scoreboard set then retire
        clear_in(); sb_set = 1'b1; sb_set_addr = 5'd3; raddr0 = 5'd3;
        cyc();
        check_val("x3_busy",   64'(busy_vec[3]), 64'h1);
        check_val("cnt_one",   64'(busy_cnt), 64'h1);
        clear_in(); set_wr(1, 3, 32'h33, 1'b1);
        cyc();
        check_val("x3_free",   64'(busy_vec[3]), 64'h0);
        check_val("cnt_zero",  64'(busy_cnt), 64'h0);

        // Flush with concurrent set
        clear_in(); sb_set = 1'b1; sb_set_addr = 5'd4;  cyc();
        clear_in(); sb_set = 1'b1; sb_set_addr = 5'd9;  cyc();
        check_val("cnt_two",   64'(busy_cnt), 64'h2);
        clear_in(); sb_flush = 1'b1; sb_set = 1'b1; sb_set_addr = 5'd12; cyc();
        check_val("flush_vec", 64'(busy_vec), 64'h0000_1000);
        check_val("flush_cnt", 64'(busy_cnt), 64'h1);

        // Set and retiring write to the same register: stays busy
        clear_in(); sb_set = 1'b1; sb_set_addr = 5'd6; set_wr(0, 6, 32'h66, 1'b1);
        cyc();
        check_val("set_clr_6", 64'(busy_vec[6]), 64'h1);
        clear_in(); sb_set = 1'b1; sb_set_addr = 5'd0;
        cyc();
        check_val("set_x0",    64'(busy_vec[0]), 64'h0);

        // No bypass: write is invisible until after the edge
        clear_in(); set_wr(0, 10, 32'hA5A5A5A5, 1'b0); raddr1 = 5'd10;
        #1;
        check_val("x10_old",   64'(rd1), 64'h0);
        cyc();
        check_val("x10_new",   64'(rd1), 64'hA5A5A5A5);

        // Random traffic over a narrow address window to provoke overlaps
        for (int i = 0; i < 300; i++) begin
            clear_in();
            for (int p = 0; p < NWR; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(p, int'($urandom_range(0, 7)), XLEN'($urandom), 1'($urandom_range(0, 1)));
            end
            sb_set      = ($urandom_range(0, 3) == 0);
            sb_set_addr = AW'($urandom_range(0, 7));
            sb_flush    = ($urandom_range(0, 9) == 0);
            raddr0      = AW'($urandom_range(0, 7));
            raddr1      = AW'($urandom_range(0, 7));
            cyc();
        end

        // Asynchronous reset between edges
        clear_in(); set_wr(0, 1, 32'h1, 1'b0); sb_set = 1'b1; sb_set_addr = 5'd2;
        raddr0 = 5'd1; raddr1 = 5'd2;
        cyc();
        clear_in();
        #3;
        rst_l = 1'b0;
        #1;
        model_reset();
        check_val("arst_rd0",    64'(rd0), 64'h0);
        check_val("arst_rbusy1", 64'(rbusy1), 64'h0);
        check_val("arst_vec",    64'(busy_vec), 64'h0);
        check_val("arst_cnt",    64'(busy_cnt), 64'h0);
        #2;
        rst_l = 1'b1;
        set_wr(0, 1, 32'h55, 1'b0); sb_set = 1'b1; sb_set_addr = 5'd2;
        cyc();
        check_val("post_rst_x1", 64'(rd0), 64'h55);
        check_val("post_rst_b2", 64'(rbusy1), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
